// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and parameter helpers for the boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        CHECK,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } boot_state_t;

    typedef logic [15:0] len_t;

    // Clock cycles per UART bit
    function automatic int bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Word address width; a single-word memory still gets one address bit
    function automatic int addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchroniser
module uart_rx #(
    parameter int BIT_CYC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);
    localparam int HALF = BIT_CYC / 2;
    localparam int CW   = $clog2(BIT_CYC);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            valid_q, ferr_q;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit-level FSM: mid-bit sampling driven by a per-bit cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        // A start bit that is high again at mid-bit was a glitch
                        state_q <= sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CW'(BIT_CYC - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CW'(BIT_CYC - 1)) begin
                        cnt_q   <= '0;
                        valid_q <= sync2_q;
                        ferr_q  <= !sync2_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_valid = valid_q;
    assign rx_byte  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - UART program loader that fills IMEM and releases CPU reset
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter  int CLK_HZ      = 50_000_000,
    parameter  int BAUD        = 115_200,
    parameter  int IMEM_WORDS  = 256,
    parameter  int TIMEOUT_CYC = 16 * 10 * (CLK_HZ / BAUD),
    localparam int AW          = addr_w(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_rst,
    output logic          load_done,
    output logic          load_err
);
    localparam int BIT_CYC = bit_cyc(CLK_HZ, BAUD);
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);

    logic        rx_valid, rx_ferr;
    logic [7:0]  rx_byte;

    boot_state_t   state_q;
    len_t          len_q;
    logic [1:0]    byte_idx_q;
    logic [AW-1:0] word_idx_q;
    logic [31:0]   wbuf_q;
    logic [TW-1:0] tmo_q;
    logic          imem_we_q;
    logic [AW-1:0] imem_addr_q;
    logic [31:0]   imem_wdata_q;
    logic          cpu_rst_q, done_q, err_q;
    logic          tmo_hit;

    uart_rx #(.BIT_CYC(BIT_CYC)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Loader FSM: length header, per-word assembly, write strobe, terminal states
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LEN_LO;
            len_q        <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            wbuf_q       <= '0;
            tmo_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (rx_ferr && state_q != DONE) begin
                state_q   <= ERROR;
                cpu_rst_q <= 1'b1;
                err_q     <= 1'b1;
            end else begin
                case (state_q)
                    LEN_LO: begin
                        if (rx_valid) begin
                            len_q[7:0] <= rx_byte;
                            tmo_q      <= '0;
                            state_q    <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (rx_valid) begin
                            len_q[15:8] <= rx_byte;
                            state_q     <= CHECK;
                        end else if (tmo_hit) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (len_q == '0) begin
                            // Empty image: keep memory as is and start the CPU directly
                            state_q   <= DONE;
                            cpu_rst_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (32'(len_q) > 32'(IMEM_WORDS)) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            byte_idx_q <= '0;
                            word_idx_q <= '0;
                            tmo_q      <= '0;
                            state_q    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (rx_valid) begin
                            wbuf_q[8*byte_idx_q +: 8] <= rx_byte;
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tmo_q      <= '0;
                            if (byte_idx_q == 2'd3) begin
                                state_q <= WRITE;
                            end
                        end else if (tmo_hit) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    WRITE: begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_idx_q;
                        imem_wdata_q <= wbuf_q;
                        // The last word leaves word_idx on the final address instead of wrapping
                        if (16'(word_idx_q) == len_q - 16'd1) begin
                            state_q <= DONE;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                            byte_idx_q <= '0;
                            tmo_q      <= '0;
                            state_q    <= LOAD;
                        end
                        if (rx_valid) begin
                            wbuf_q[7:0] <= rx_byte;
                            byte_idx_q  <= 2'd1;
                        end
                    end
                    DONE: begin
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                    ERROR: begin
                        cpu_rst_q <= 1'b1;
                        err_q     <= 1'b1;
                    end
                    default: state_q <= ERROR;
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for the UART boot loader
module tb_imem_boot_loader;
    localparam int NW  = 8;
    localparam int BIT = 10;
    localparam int TMO = 400;
    localparam int TOL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        imem_we;
    logic [2:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst, load_done, load_err;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  last_fall = 0;
    int  last_we_cyc = -1;
    int  rst_fall_cyc = -1;
    logic prev_cpu_rst = 1'b1;

    imem_boot_loader #(
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000),
        .IMEM_WORDS  (NW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got cycle %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every write strobe is matched against the head of the scoreboard
    always begin
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
        if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) rst_fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        last_fall = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_we_cyc  = -1;
        rst_fall_cyc = -1;
        exp_q.delete();
    endtask

    task automatic wait_end(output int t);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (load_done === 1'b1 || load_err === 1'b1) break;
        end
        t = cyc;
        if (k == 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_end: got no completion expected done or err within 3000 cycles");
        end
    endtask

    // Reference model: an image of n words is legal when 1..NW (or 0 = empty);
    // legal images produce writes 0..n-1 in order, then the CPU runs.
    task automatic run_load(input int n, input logic [31:0] w[$]);
        bit   exp_err;
        int   nwr, t;
        logic [31:0] word;
        logic [15:0] nl;
        wr_t  e;
        exp_err = (n > NW);
        nwr     = exp_err ? 0 : n;
        for (int i = 0; i < nwr; i++) begin
            e.addr = 3'(i);
            e.data = w[i];
            exp_q.push_back(e);
        end
        nl = 16'(n);
        send_byte(nl[7:0], 1'b0);
        send_byte(nl[15:8], 1'b0);
        for (int i = 0; i < nwr; i++) begin
            word = w[i];
            for (int b = 0; b < 4; b++) send_byte(word[8*b +: 8], 1'b0);
        end
        wait_end(t);
        repeat (4) @(posedge clk);
        #1;
        check("load_err", 32'(load_err), 32'(exp_err));
        check("load_done", 32'(load_done), 32'(!exp_err));
        check("cpu_rst", 32'(cpu_rst), 32'(exp_err));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        if (nwr > 0) begin
            check("rst_after_last_we", 32'(rst_fall_cyc), 32'(last_we_cyc + 1));
            check_win("we_latency", last_we_cyc, last_fall + 100 - TOL, last_fall + 100 + TOL);
        end else if (n == 0) begin
            check_win("empty_rst_latency", rst_fall_cyc, last_fall + 100 - TOL, last_fall + 100 + TOL);
        end
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] none[$];
        int n, t, k;
        bit held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;

        // Directed two-word image
        do_reset();
        w = '{32'h00500313, 32'h00130313};
        run_load(2, w);

        // Random images, including the full-depth boundary
        for (int it = 0; it < 3; it++) begin
            do_reset();
            n = (it == 0) ? NW : int'($urandom_range(1, NW - 1));
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom());
            run_load(n, w);
        end

        // Empty image
        do_reset();
        run_load(0, none);

        // Oversize image: error, CPU stays held
        do_reset();
        run_load(NW + 1, none);
        held = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (cpu_rst !== 1'b1) held = 1'b0;
        end
        check("err_cpu_held", 32'(held), 32'd1);

        // Timeout after a partial word
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        for (k = 0; k < 700; k++) begin
            if (load_err === 1'b1) break;
            @(posedge clk);
            #1;
        end
        check_win("timeout_latency", cyc, last_fall + 98 + TMO - TOL - 1, last_fall + 98 + TMO + TOL + 1);
        check("timeout_err", 32'(load_err), 32'd1);
        check("timeout_no_write", 32'(last_we_cyc), 32'hFFFF_FFFF);

        // Short glitch must not produce a byte; a following load parses cleanly
        do_reset();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        check("glitch_no_err", 32'(load_err), 32'd0);
        w = '{32'h13572468};
        run_load(1, w);

        // Framing error
        do_reset();
        send_byte(8'h01, 1'b1);
        repeat (5) @(negedge clk);
        check("ferr_err", 32'(load_err), 32'd1);
        check("ferr_cpu_rst", 32'(cpu_rst), 32'd1);

        // Reset in the middle of a word, then a fresh load
        do_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w = '{32'hDEADBEEF};
        run_load(1, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test expected completion before time limit");
        $fatal(1, "watchdog");
    end

endmodule
